// File: rtl/pipe_stage_skid.sv
// Pipeline stage latch with a 2-entry skid buffer, flush, and halt-lock.
// Latency: an accepted beat appears on o_* one falling edge later when the stage is empty or draining.
// Backpressure: o_ready is registered and drops when both entries are full or a halt beat has been taken.
module pipe_stage_skid #(
  parameter int NB_DATA       = 64,
  parameter int NB_CTRL       = 9,
  parameter int REG_WRITE_BIT = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable_pipe,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_halt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_reg_write,
  output logic               o_halt_detected,
  output logic [1:0]         o_count
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NB_CTRL-1:0] head_ctrl, head_ctrl_nxt;
  logic [NB_CTRL-1:0] skid_ctrl, skid_ctrl_nxt;
  logic [NB_DATA-1:0] head_data, head_data_nxt;
  logic [NB_DATA-1:0] skid_data, skid_data_nxt;
  logic               head_halt, head_halt_nxt;
  logic               skid_halt, skid_halt_nxt;
  logic               lock, lock_nxt;
  logic               ready_q, ready_nxt;
  logic               acc, dlv, halt_held;

  assign o_valid         = (state != EMPTY);
  assign o_ready         = ready_q;
  assign o_ctrl          = head_ctrl;
  assign o_data          = head_data;
  assign o_reg_write     = o_valid & head_ctrl[REG_WRITE_BIT];
  assign o_halt_detected = o_valid & head_halt;
  assign o_count         = state;

  assign acc = i_valid & ready_q & i_enable_pipe;
  assign dlv = o_valid & i_ready & i_enable_pipe;

  // The halt beat is still inside the stage (not yet handed downstream).
  assign halt_held = (o_valid & head_halt) | ((state == FULL) & skid_halt);

  // State register; all updates on the falling edge, like the rest of the pipeline latches.
  always_ff @(negedge i_clock) begin
    if (i_reset) begin
      state     <= EMPTY;
      head_ctrl <= '0;
      skid_ctrl <= '0;
      head_data <= '0;
      skid_data <= '0;
      head_halt <= 1'b0;
      skid_halt <= 1'b0;
      lock      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_nxt;
      head_ctrl <= head_ctrl_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      head_data <= head_data_nxt;
      skid_data <= skid_data_nxt;
      head_halt <= head_halt_nxt;
      skid_halt <= skid_halt_nxt;
      lock      <= lock_nxt;
      ready_q   <= ready_nxt;
    end
  end

  // Next-state: occupancy transitions, flush, and halt-lock tracking.
  always_comb begin
    state_nxt     = state;
    head_ctrl_nxt = head_ctrl;
    skid_ctrl_nxt = skid_ctrl;
    head_data_nxt = head_data;
    skid_data_nxt = skid_data;
    head_halt_nxt = head_halt;
    skid_halt_nxt = skid_halt;
    lock_nxt      = lock;
    ready_nxt     = ready_q;

    if (i_enable_pipe) begin
      if (i_flush) begin
        // Incoming beat is dropped; a beat handed off on this edge counts as delivered,
        // so a halt leaving right now keeps the lock.
        state_nxt     = EMPTY;
        head_ctrl_nxt = '0;
        skid_ctrl_nxt = '0;
        head_halt_nxt = 1'b0;
        skid_halt_nxt = 1'b0;
        if (halt_held && !(dlv && head_halt)) begin
          lock_nxt = 1'b0;
        end
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              state_nxt     = ONE;
              head_ctrl_nxt = i_ctrl;
              head_data_nxt = i_data;
              head_halt_nxt = i_halt;
            end
          end
          ONE: begin
            if (acc && !dlv) begin
              state_nxt     = FULL;
              skid_ctrl_nxt = i_ctrl;
              skid_data_nxt = i_data;
              skid_halt_nxt = i_halt;
            end else if (acc && dlv) begin
              head_ctrl_nxt = i_ctrl;
              head_data_nxt = i_data;
              head_halt_nxt = i_halt;
            end else if (dlv) begin
              state_nxt = EMPTY;
            end
          end
          FULL: begin
            if (dlv) begin
              state_nxt     = ONE;
              head_ctrl_nxt = skid_ctrl;
              head_data_nxt = skid_data;
              head_halt_nxt = skid_halt;
            end
          end
          default: state_nxt = EMPTY;
        endcase
        if (acc && i_halt) begin
          lock_nxt = 1'b1;
        end
      end
      ready_nxt = (state_nxt != FULL) && !lock_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a scoreboard queue of expected delivered beats.
// Inputs change just after each falling edge; the monitor samples on the rising edge.
// Stall, flush, halt-lock and freeze scenarios are each followed by explicit output checks.
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [63:0] data;
    logic        halt;
  } beat_t;

  logic        clk = 1'b0;
  logic        i_reset, i_enable_pipe, i_flush, i_valid, i_ready, i_halt;
  logic [8:0]  i_ctrl;
  logic [63:0] i_data;
  logic        o_ready, o_valid, o_reg_write, o_halt_detected;
  logic [8:0]  o_ctrl;
  logic [63:0] o_data;
  logic [1:0]  o_count;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];

  pipe_stage_skid #(.NB_DATA(64), .NB_CTRL(9), .REG_WRITE_BIT(8)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable_pipe(i_enable_pipe), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl), .i_data(i_data), .i_halt(i_halt),
    .o_valid(o_valid), .i_ready(i_ready), .o_ctrl(o_ctrl), .o_data(o_data),
    .o_reg_write(o_reg_write), .o_halt_detected(o_halt_detected), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [63:0] d, input logic h);
    i_valid = v;
    i_ctrl  = c;
    i_data  = d;
    i_halt  = h;
  endtask

  task automatic expect_beat(input logic [8:0] c, input logic [63:0] d, input logic h);
    beat_t b;
    b.ctrl = c;
    b.data = d;
    b.halt = h;
    exp_q.push_back(b);
  endtask

  // Monitor: a handoff is pending for the next falling edge; compare it with the queue head.
  always @(posedge clk) begin
    if (!i_reset && i_enable_pipe && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got ctrl=%h data=%h, expected no beat", o_ctrl, o_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_ctrl", {55'd0, o_ctrl}, {55'd0, e.ctrl});
        check("beat_data", o_data, e.data);
        check("beat_halt", {63'd0, o_halt_detected}, {63'd0, e.halt});
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_enable_pipe = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    drive(1'b0, 9'h0, 64'h0, 1'b0);
    tick(); tick();
    i_reset = 1'b0;
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_count", {62'd0, o_count}, 64'd0);
    check("rst_ctrl",  {55'd0, o_ctrl}, 64'd0);
    check("rst_data",  o_data, 64'd0);
    check("rst_halt",  {63'd0, o_halt_detected}, 64'd0);

    // 1: single beat through an empty stage
    i_ready = 1'b1;
    drive(1'b1, 9'h100, 64'hA, 1'b0); expect_beat(9'h100, 64'hA, 1'b0);
    tick();
    drive(1'b0, 9'h0, 64'h0, 1'b0);
    check("t1_valid", {63'd0, o_valid}, 64'd1);
    check("t1_regwr", {63'd0, o_reg_write}, 64'd1);
    check("t1_count", {62'd0, o_count}, 64'd1);
    tick();
    check("t1_drained", {62'd0, o_count}, 64'd0);

    // 2: stall fills head and skid; extra offer is refused; release drains in order
    i_ready = 1'b0;
    drive(1'b1, 9'h001, 64'h11, 1'b0); expect_beat(9'h001, 64'h11, 1'b0);
    tick();
    drive(1'b1, 9'h102, 64'h22, 1'b0); expect_beat(9'h102, 64'h22, 1'b0);
    tick();
    drive(1'b1, 9'h0C3, 64'h2F, 1'b0);
    check("t2_count", {62'd0, o_count}, 64'd2);
    check("t2_ready", {63'd0, o_ready}, 64'd0);
    check("t2_head",  o_data, 64'h11);
    check("t2_regwr", {63'd0, o_reg_write}, 64'd0);
    tick();
    drive(1'b0, 9'h0, 64'h0, 1'b0);
    check("t2_full_hold", {62'd0, o_count}, 64'd2);
    i_ready = 1'b1;
    tick();
    check("t2_head_b", o_data, 64'h22);
    tick();
    check("t2_empty", {62'd0, o_count}, 64'd0);

    // 3: flush a full stage with a beat offered on the same edge
    i_ready = 1'b0;
    drive(1'b1, 9'h1FF, 64'h33, 1'b0); tick();
    drive(1'b1, 9'h0AA, 64'h44, 1'b0); tick();
    check("t3_full", {62'd0, o_count}, 64'd2);
    drive(1'b1, 9'h155, 64'h4F, 1'b0); i_flush = 1'b1;
    tick();
    i_flush = 1'b0; drive(1'b0, 9'h0, 64'h0, 1'b0);
    check("t3_valid", {63'd0, o_valid}, 64'd0);
    check("t3_count", {62'd0, o_count}, 64'd0);
    check("t3_ctrl",  {55'd0, o_ctrl}, 64'd0);
    check("t3_ready", {63'd0, o_ready}, 64'd1);
    check("t3_data_kept", o_data, 64'h33);

    // 4: halt beat locks the stage; lock survives flush after delivery, reset clears it
    drive(1'b1, 9'h100, 64'h55, 1'b1); expect_beat(9'h100, 64'h55, 1'b1);
    tick();
    drive(1'b1, 9'h101, 64'h5A, 1'b0);
    check("t4_ready_lock", {63'd0, o_ready}, 64'd0);
    check("t4_halt_det", {63'd0, o_halt_detected}, 64'd1);
    i_ready = 1'b1;
    tick();
    check("t4_halt_gone", {63'd0, o_halt_detected}, 64'd0);
    check("t4_not_taken", {62'd0, o_count}, 64'd0);
    check("t4_lock_held", {63'd0, o_ready}, 64'd0);
    drive(1'b0, 9'h0, 64'h0, 1'b0); i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("t4_lock_after_flush", {63'd0, o_ready}, 64'd0);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    check("t4_reset_unlock", {63'd0, o_ready}, 64'd1);

    // 5: flush while the halt beat is still held releases the lock
    i_ready = 1'b0;
    drive(1'b1, 9'h000, 64'h66, 1'b1); tick();
    drive(1'b0, 9'h0, 64'h0, 1'b0);
    check("t5_locked", {63'd0, o_ready}, 64'd0);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    check("t5_unlocked", {63'd0, o_ready}, 64'd1);
    check("t5_count", {62'd0, o_count}, 64'd0);
    i_ready = 1'b1;
    drive(1'b1, 9'h100, 64'h77, 1'b0); expect_beat(9'h100, 64'h77, 1'b0);
    tick();
    drive(1'b0, 9'h0, 64'h0, 1'b0);
    check("t5_new_count", {62'd0, o_count}, 64'd1);
    check("t5_new_data", o_data, 64'h77);
    tick();

    // 6: enable low freezes everything, flush included
    i_ready = 1'b0;
    drive(1'b1, 9'h101, 64'h88, 1'b0); expect_beat(9'h101, 64'h88, 1'b0);
    tick();
    i_enable_pipe = 1'b0; i_flush = 1'b1; i_ready = 1'b1;
    drive(1'b1, 9'h0F0, 64'h99, 1'b1);
    tick(); tick();
    check("t6_valid", {63'd0, o_valid}, 64'd1);
    check("t6_count", {62'd0, o_count}, 64'd1);
    check("t6_ctrl",  {55'd0, o_ctrl}, 64'h101);
    check("t6_data",  o_data, 64'h88);
    check("t6_ready", {63'd0, o_ready}, 64'd1);
    i_enable_pipe = 1'b1; i_flush = 1'b0;
    drive(1'b0, 9'h0, 64'h0, 1'b0);
    tick();
    check("t6_drained", {62'd0, o_count}, 64'd0);

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
